// File: rtl/multicycle_pkg.sv
// -----------------------------------------------------------------------------
// multicycle_pkg
// Shared definitions for the multicycle controller: FSM state type, opcode and
// ALU-class constants, and a small state-classification helper.
// No ports (package).
// -----------------------------------------------------------------------------
package multicycle_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5,
        ST_ERR    = 3'd6
    } state_t;

    localparam logic [5:0] OP_RTYPE    = 6'h00;
    localparam logic [5:0] OP_HALT     = 6'h3F;

    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_ADD   = 2'b00;

    // States in which an instruction is in flight.
    function automatic logic is_busy_state(input state_t s);
        return (s == ST_FETCH) || (s == ST_DECODE) || (s == ST_EXEC) || (s == ST_WB);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl_if
// Bundles the controller's command/status signals.
//   master : the controller (drives ir_write, pc_write, reg_write, alu_op,
//            busy, halted, err; samples start, im_ready, opcode)
//   slave  : the surrounding datapath / environment
// Optional feature macro: MULTICYCLE_CTRL_PERF_EN adds retired_cnt and
// stall_cnt (32-bit performance counters driven by the master).
// -----------------------------------------------------------------------------
interface multicycle_ctrl_if;

    logic       start;
    logic       im_ready;
    logic [5:0] opcode;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic [1:0] alu_op;
    logic       busy;
    logic       halted;
    logic       err;
`ifdef MULTICYCLE_CTRL_PERF_EN
    logic [31:0] retired_cnt;
    logic [31:0] stall_cnt;
`endif

    modport master (
        input  start, im_ready, opcode,
        output ir_write, pc_write, reg_write, alu_op, busy, halted, err
`ifdef MULTICYCLE_CTRL_PERF_EN
        , output retired_cnt, stall_cnt
`endif
    );

    modport slave (
        output start, im_ready, opcode,
        input  ir_write, pc_write, reg_write, alu_op, busy, halted, err
`ifdef MULTICYCLE_CTRL_PERF_EN
        , input retired_cnt, stall_cnt
`endif
    );

endinterface

// File: rtl/fetch_timer.sv
// -----------------------------------------------------------------------------
// fetch_timer
// Saturating count of cycles spent waiting for instruction memory in FETCH,
// with the timeout compare.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   clear      : zero the counter (entry into FETCH)
//   count_en   : a waiting cycle (FETCH with im_ready low)
//   timeout    : this waiting cycle is the TIMEOUT-th one
// -----------------------------------------------------------------------------
module fetch_timer #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic count_en,
    output logic timeout
);

    localparam logic [7:0] LIMIT = TIMEOUT[7:0];

    logic [7:0] wait_cnt_r;
    logic [7:0] wait_inc_s;
    logic       sat_s;

    // Saturating increment and timeout compare on the post-increment value.
    always_comb begin
        sat_s      = (wait_cnt_r == 8'hFF);
        wait_inc_s = wait_cnt_r;
        if (sat_s) begin
            wait_inc_s = wait_cnt_r;
        end else begin
            wait_inc_s = wait_cnt_r + 8'd1;
        end
        if (count_en && (wait_inc_s >= LIMIT)) begin
            timeout = 1'b1;
        end else begin
            timeout = 1'b0;
        end
    end

    // Wait counter register; clear has priority, never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_r <= 8'd0;
        end else if (clear) begin
            wait_cnt_r <= 8'd0;
        end else if (count_en) begin
            wait_cnt_r <= wait_inc_s;
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
// Control FSM for a multicycle processor: IDLE, FETCH, DECODE, EXEC, WB,
// HALT, ERR.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : multicycle_ctrl_if.master (start, im_ready, opcode in;
//            ir_write, pc_write, reg_write, alu_op, busy, halted, err out)
// Parameter FETCH_TIMEOUT (1..255): waiting cycles in FETCH before ERR.
// Optional feature macro: MULTICYCLE_CTRL_PERF_EN (retired/stall counters).
// -----------------------------------------------------------------------------
module multicycle_ctrl
    import multicycle_pkg::*;
#(
    parameter int unsigned FETCH_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    multicycle_ctrl_if.master bus
);

    state_t     state_r;
    state_t     state_next_s;
    logic       timeout_s;
    logic       clear_s;
    logic       count_en_s;
    logic       ir_write_s;
    logic       halt_pc_s;
    logic       busy_r;
    logic       halted_r;
    logic       err_r;
    logic       reg_write_r;
    logic [1:0] alu_op_r;

    fetch_timer #(.TIMEOUT(FETCH_TIMEOUT)) u_fetch_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear_s),
        .count_en (count_en_s),
        .timeout  (timeout_s)
    );

    // Next-state logic; start is only honoured in IDLE, HALT and ERR.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) state_next_s = ST_FETCH;
                else           state_next_s = ST_IDLE;
            end
            ST_FETCH: begin
                if (bus.im_ready)  state_next_s = ST_DECODE;
                else if (timeout_s) state_next_s = ST_ERR;
                else               state_next_s = ST_FETCH;
            end
            ST_DECODE: begin
                if (bus.opcode == OP_RTYPE)     state_next_s = ST_EXEC;
                else if (bus.opcode == OP_HALT) state_next_s = ST_HALT;
                else                            state_next_s = ST_ERR;
            end
            ST_EXEC: state_next_s = ST_WB;
            ST_WB:   state_next_s = ST_FETCH;
            ST_HALT, ST_ERR: begin
                if (bus.start) state_next_s = ST_FETCH;
                else           state_next_s = state_r;
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Timer control: clear on entry into FETCH, count waiting FETCH cycles.
    always_comb begin
        clear_s    = 1'b0;
        count_en_s = 1'b0;
        if ((state_next_s == ST_FETCH) && (state_r != ST_FETCH)) clear_s = 1'b1;
        else                                                    clear_s = 1'b0;
        if ((state_r == ST_FETCH) && !bus.im_ready) count_en_s = 1'b1;
        else                                        count_en_s = 1'b0;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= ST_IDLE;
        else        state_r <= state_next_s;
    end

    // State-only outputs registered from the next state so they line up with
    // the state register and come straight out of flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r      <= 1'b0;
            halted_r    <= 1'b0;
            err_r       <= 1'b0;
            reg_write_r <= 1'b0;
            alu_op_r    <= ALUOP_ADD;
        end else begin
            busy_r      <= is_busy_state(state_next_s);
            halted_r    <= (state_next_s == ST_HALT);
            err_r       <= (state_next_s == ST_ERR);
            reg_write_r <= (state_next_s == ST_WB);
            if ((state_next_s == ST_EXEC) || (state_next_s == ST_WB)) alu_op_r <= ALUOP_RTYPE;
            else                                                      alu_op_r <= ALUOP_ADD;
        end
    end

    // ir_write and the HALT pc_write are qualified by im_ready / the IR opcode
    // in the same cycle, so they are decodes of the state register ANDed with
    // those synchronous inputs.
    always_comb begin
        ir_write_s = 1'b0;
        halt_pc_s  = 1'b0;
        if ((state_r == ST_FETCH) && bus.im_ready) ir_write_s = 1'b1;
        else                                       ir_write_s = 1'b0;
        if ((state_r == ST_DECODE) && (bus.opcode == OP_HALT)) halt_pc_s = 1'b1;
        else                                                   halt_pc_s = 1'b0;
    end

    assign bus.ir_write  = ir_write_s;
    assign bus.pc_write  = reg_write_r | halt_pc_s;
    assign bus.reg_write = reg_write_r;
    assign bus.alu_op    = alu_op_r;
    assign bus.busy      = busy_r;
    assign bus.halted    = halted_r;
    assign bus.err       = err_r;

`ifdef MULTICYCLE_CTRL_PERF_EN
    logic [31:0] retired_cnt_r;
    logic [31:0] stall_cnt_r;

    // Performance counters; they only move in WB / waiting FETCH, so they
    // naturally hold in HALT and ERR. Both wrap modulo 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_cnt_r <= 32'd0;
            stall_cnt_r   <= 32'd0;
        end else begin
            if (state_r == ST_WB) retired_cnt_r <= retired_cnt_r + 32'd1;
            else                  retired_cnt_r <= retired_cnt_r;
            if (count_en_s) stall_cnt_r <= stall_cnt_r + 32'd1;
            else            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign bus.retired_cnt = retired_cnt_r;
    assign bus.stall_cnt   = stall_cnt_r;
`endif

endmodule
